// File: rtl/picomips_pkg.sv
// Shared picoMIPS types and defaults: switch-input handshake FSM state
// encoding and the default debounce length.
package picomips_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } hs_state_t;

  localparam int DEBOUNCE_DEFAULT = 50000;
  localparam int CW_DEFAULT       = 16;

endpackage

// File: rtl/ready_debounce.sv
// Ready-switch conditioning: 2-flop synchronizer followed by a stable-run
// counter; db only changes after DEBOUNCE consecutive differing samples.
module ready_debounce import picomips_pkg::*; #(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic db
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_pipe;
  logic          ready_s;
  logic [CW-1:0] cnt;

  assign ready_s = sync_pipe[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], ready};
  end

  // Any sample agreeing with db restarts the run, so short glitches never land.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (ready_s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= ~db;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/input_handshake_ctrl.sv
// Switch-input handshake: stalls the PC until a debounced press, strobes
// sw_valid once, then demands a release. SW_LATCH_EN registers sw_data.
module input_handshake_ctrl import picomips_pkg::*; #(
  parameter int n        = 8,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
  parameter int CW       = CW_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ready,
  input  logic [n-1:0] sw,
  input  logic         wait_req,
  output logic         stall,
  output logic         sw_valid,
  output logic [n-1:0] sw_data,
  output logic         busy
);

  hs_state_t state, state_next;
  logic      db;

  ready_debounce #(.DEBOUNCE(DEBOUNCE), .CW(CW)) u_db (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .db    (db)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A switch already held when the request arrives is not a press.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:         if (wait_req) state_next = db ? WAIT_RELEASE : WAIT_PRESS;
      WAIT_PRESS:   if (db) state_next = CAPTURE;
                    else if (!wait_req) state_next = IDLE;
      CAPTURE:      state_next = WAIT_RELEASE;
      WAIT_RELEASE: if (!db) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_comb begin
    stall    = wait_req & (state != CAPTURE);
    sw_valid = (state == CAPTURE);
    busy     = (state != IDLE);
  end

`ifdef SW_LATCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        sw_data <= '0;
    else if (state_next == CAPTURE &&
             state == WAIT_PRESS)     sw_data <= sw;
  end
`else
  assign sw_data = sw;
`endif

endmodule

// File: tb/tb_input_handshake_ctrl.sv
// Bench for input_handshake_ctrl with DEBOUNCE=4: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_input_handshake_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0, reset = 1'b1, ready = 1'b0, wait_req = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       stall, sw_valid, busy;
  logic [7:0] sw_data;

  int tests = 0, fails = 0;

  input_handshake_ctrl #(.n(8), .DEBOUNCE(D), .CW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .sw       (sw),
    .wait_req (wait_req),
    .stall    (stall),
    .sw_valid (sw_valid),
    .sw_data  (sw_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: db flips once the last D synchronized samples all
  // disagree with it; a request is pending until a press, then needs release.
  bit         m_s0 = 0, m_s1 = 0, m_db = 0;
  bit         hist[$];
  bit         m_armed = 0, m_strobe = 0, m_hold = 0;
  logic [7:0] m_data = 8'h00;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_s0 = 0; m_s1 = 0; m_db = 0; hist.delete();
      m_armed = 0; m_strobe = 0; m_hold = 0; m_data = 8'h00;
    end else begin
      bit flip;
      hist.push_back(m_s1);
      if (hist.size() > D) hist.pop_front();
      flip = (hist.size() == D);
      foreach (hist[i]) if (hist[i] == m_db) flip = 0;
      if (m_strobe) begin
        m_strobe = 0; m_hold = 1;
      end else if (m_hold) begin
        if (!m_db) m_hold = 0;
      end else if (m_armed) begin
        if (m_db) begin m_armed = 0; m_strobe = 1; m_data = sw; end
        else if (!wait_req) m_armed = 0;
      end else if (wait_req) begin
        if (m_db) m_hold = 1; else m_armed = 1;
      end
      if (flip) begin m_db = ~m_db; hist.delete(); end
      m_s1 = m_s0; m_s0 = ready;
    end
  end

  task automatic release_idle();
    wait_req = 0; ready = 0;
    repeat (D + 4) @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL release_idle busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; wait_req = 1; sw = 8'h5A; ready = 0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL reset_stall got %b want 1", stall); end
    tests++; if (sw_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", sw_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef SW_LATCH_EN
    tests++; if (sw_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", sw_data); end
`else
    tests++; if (sw_data !== 8'h5A) begin fails++; $display("FAIL reset_data got %h want 5a", sw_data); end
`endif
    wait_req = 0; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_low got %b want 0", stall); end
  endtask

  task automatic test_press_latency();
    @(negedge clk);
    reset = 0; wait_req = 1; sw = 8'hA5; ready = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      tests++; if (stall !== (c != 17)) begin fails++; $display("FAIL press_stall c=%0d got %b want %b", c, stall, c != 17); end
      tests++; if (sw_valid !== (c == 17)) begin fails++; $display("FAIL press_valid c=%0d got %b want %b", c, sw_valid, c == 17); end
      tests++; if (busy !== (c >= 1)) begin fails++; $display("FAIL press_busy c=%0d got %b want %b", c, busy, c >= 1); end
      if (c >= 17) begin
        tests++; if (sw_data !== 8'hA5) begin fails++; $display("FAIL press_data c=%0d got %h want a5", c, sw_data); end
      end
      if (c == 10) ready = 1;
      @(negedge clk);
    end
    release_idle();
  endtask

  task automatic test_glitch();
    int pulses = 0, unstalled = 0;
    wait_req = 1; ready = 0;
    for (int c = 0; c < 18; c++) begin
      if (c == 3) ready = 1;
      if (c == 6) ready = 0;
      @(negedge clk); #1;
      if (sw_valid) pulses++;
      if (!stall) unstalled++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    tests++; if (unstalled != 0) begin fails++; $display("FAIL glitch_stall_drops got %0d want 0", unstalled); end
    tests++; if (dut.u_db.db !== 1'b0) begin fails++; $display("FAIL glitch_db got %b want 0", dut.u_db.db); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy got %b want 1", busy); end
    wait_req = 0;
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
  endtask

  task automatic test_held_before();
    int pulses = 0;
    ready = 1; wait_req = 0;
    repeat (D + 4) @(negedge clk);
    wait_req = 1;
    repeat (10) begin @(negedge clk); #1; if (sw_valid) pulses++; end
    tests++; if (pulses != 0) begin fails++; $display("FAIL held_no_strobe got %0d want 0", pulses); end
    tests++; if (busy !== 1'b1 || stall !== 1'b1) begin fails++; $display("FAIL held_wait busy=%b stall=%b want 1 1", busy, stall); end
    ready = 0;
    repeat (D + 4) begin @(negedge clk); #1; if (sw_valid) pulses++; end
    ready = 1;
    repeat (D + 6) begin @(negedge clk); #1; if (sw_valid) pulses++; end
    tests++; if (pulses != 1) begin fails++; $display("FAIL held_then_press got %0d want 1", pulses); end
    release_idle();
  endtask

  task automatic test_back_to_back();
    int pulses = 0, unstalled = 0;
    wait_req = 1; ready = 0;
    repeat (2) @(negedge clk);
    ready = 1;
    repeat (D + 6) begin @(negedge clk); #1; if (sw_valid) pulses++; end
    tests++; if (pulses != 1) begin fails++; $display("FAIL b2b_first got %0d want 1", pulses); end
    repeat (15) begin @(negedge clk); #1; if (sw_valid) pulses++; if (!stall) unstalled++; end
    tests++; if (unstalled != 0) begin fails++; $display("FAIL b2b_stall_drops got %0d want 0", unstalled); end
    ready = 0;
    repeat (D + 4) begin @(negedge clk); #1; if (sw_valid) pulses++; end
    ready = 1;
    repeat (D + 6) begin @(negedge clk); #1; if (sw_valid) pulses++; end
    tests++; if (pulses != 2) begin fails++; $display("FAIL b2b_total got %0d want 2", pulses); end
    release_idle();
  endtask

  task automatic test_reset_mid();
    int first = -1;
    wait_req = 1; ready = 0; sw = 8'h77;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_pre_busy got %b want 1", busy); end
    #1 reset = 1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy); end
`ifdef SW_LATCH_EN
    tests++; if (sw_data !== 8'h00) begin fails++; $display("FAIL mid_data got %h want 00", sw_data); end
`else
    tests++; if (sw_data !== 8'h77) begin fails++; $display("FAIL mid_data got %h want 77", sw_data); end
`endif
    ready = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int c = 0; c < D + 8; c++) begin
      #1;
      if (sw_valid && first < 0) first = c;
      @(negedge clk);
    end
    tests++; if (first != D + 3) begin fails++; $display("FAIL mid_strobe_cycle got %0d want %0d", first, D + 3); end
    release_idle();
  endtask

  task automatic test_data_hold();
    @(negedge clk);
    sw = 8'h3C; wait_req = 1; ready = 1;
    repeat (D + 3) @(negedge clk);
    #1;
    tests++; if (sw_valid !== 1'b1 || sw_data !== 8'h3C) begin fails++; $display("FAIL hold_capture valid=%b data=%h want 1 3c", sw_valid, sw_data); end
    sw = 8'hFF;
    @(negedge clk); #1;
`ifdef SW_LATCH_EN
    tests++; if (sw_data !== 8'h3C) begin fails++; $display("FAIL hold_data got %h want 3c", sw_data); end
`else
    tests++; if (sw_data !== 8'hFF) begin fails++; $display("FAIL hold_data got %h want ff", sw_data); end
`endif
    release_idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      tests++; if (stall !== (wait_req & ~m_strobe)) begin fails++; $display("FAIL rnd_stall c=%0d got %b want %b", c, stall, wait_req & ~m_strobe); end
      tests++; if (sw_valid !== m_strobe) begin fails++; $display("FAIL rnd_valid c=%0d got %b want %b", c, sw_valid, m_strobe); end
      tests++; if (busy !== (m_armed | m_strobe | m_hold)) begin fails++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, m_armed | m_strobe | m_hold); end
`ifdef SW_LATCH_EN
      tests++; if (sw_data !== m_data) begin fails++; $display("FAIL rnd_data c=%0d got %h want %h", c, sw_data, m_data); end
`else
      tests++; if (sw_data !== sw) begin fails++; $display("FAIL rnd_data c=%0d got %h want %h", c, sw_data, sw); end
`endif
      if ($urandom_range(0, 5) == 0) ready = ~ready;
      if ($urandom_range(0, 11) == 0) wait_req = ~wait_req;
      sw = 8'($urandom);
      if ($urandom_range(0, 249) == 0) begin reset = 1; #2 reset = 0; end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_held_before();
    test_back_to_back();
    test_reset_mid();
    test_data_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_handshake_ctrl.md
# input_handshake_ctrl

Sequences the picoMIPS core's switch-input instructions. When the decoder flags an instruction that consumes switch data, this block stalls the program counter, waits for a debounced press of the ready switch, and issues a one-cycle accept strobe with the captured switch byte. It then requires a release before a later press is accepted. It sits between the board switches, the decoder and the PC/ALU operand mux.

## Interface
- `n`, 8: data width of switch bus and `sw_data`.
- `DEBOUNCE`, 50000: consecutive stable cycles required before the debounced ready level changes; legal range ≥1.
- `CW`, 16: debounce counter width; must satisfy 2^CW > DEBOUNCE.

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ready`  in  1  raw ready switch, asynchronous to `clk`.
- `sw`  in  n  data switches.
- `wait_req`  in  1  from decoder: current instruction needs switch input.
- `stall`  out  1  holds PC (suppresses PCincr/PCabsbranch) while high.
- `sw_valid`  out  1  one-cycle strobe: input accepted, PC may advance.
- `sw_data`  out  n  operand presented to the ALU b-input mux.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Synchronizer:** 2-flop chain on `ready` → `ready_s`, reset 0.
- **Debouncer:** holds level `db`, reset 0, with a counter `cnt`, reset 0.
  - When `ready_s == db`: `cnt` clears to 0.
  - Otherwise `cnt` increments.
  - When `cnt == DEBOUNCE-1` and still differing: `db` toggles on that edge and `cnt` clears.
  - A glitch shorter than DEBOUNCE cycles never changes `db`.
- **FSM**, states IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE; reset state IDLE.
  - IDLE: `wait_req & ~db` → WAIT_PRESS; `wait_req & db` → WAIT_RELEASE, because a switch already held is not a press; otherwise stay.
  - WAIT_PRESS: `db` → CAPTURE; `~wait_req` → IDLE (abort, no strobe); otherwise stay.
  - CAPTURE: unconditionally → WAIT_RELEASE.
  - WAIT_RELEASE: `~db` → IDLE; otherwise stay.
- **Outputs** (combinational from state and inputs):
  - `stall = wait_req & (state != CAPTURE)`.
  - `sw_valid = (state == CAPTURE)`.
  - `busy = (state != IDLE)`.
- **Back-to-back input instructions:** in WAIT_RELEASE, `stall` follows `wait_req`. A second input instruction therefore stalls until release and then a new press; one press never satisfies two instructions.
- **Reset mid-operation:** returns to IDLE with `db = 0`. A switch still held after reset is debounced afresh and is treated as a new press.

## Timing
- Reset values: `stall` = `wait_req` (IDLE); `sw_valid` 0; `busy` 0; `sw_data` 0 (latched build); `db`, `cnt` and sync flops all 0.
- Press latency: `ready` rises before edge 0 and stays high; `ready_s` is high after edge 1; `db` is high after edge 1+DEBOUNCE; state is CAPTURE after edge 2+DEBOUNCE.
- `sw_valid` is high for exactly the one cycle following edge 2+DEBOUNCE, with `stall` low in that cycle. The PC advances at edge 3+DEBOUNCE.
- Release latency to IDLE: DEBOUNCE+2 edges after `ready` falls.
- `wait_req` dropping during CAPTURE has no effect; the strobe still occurs.

## Configuration
- `SW_LATCH_EN` defined:
  - `sw_data` is a register loaded from `sw` on the edge entering CAPTURE.
  - It holds until the next capture; reset value 0.
- `SW_LATCH_EN` undefined:
  - `sw_data = sw`, combinational passthrough with no register.
  - `sw_valid` and `stall` timing are unchanged.

## Structure
- Shared package `picomips_pkg` holds:
  - the `hs_state_t` enum typedef (IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE);
  - the default constant `DEBOUNCE_DEFAULT`.
- One sub-module, `ready_debounce`: synchronizer plus counter.
  - Ports: `clk`, `reset`, `ready`, `db`.
  - Parameters: `DEBOUNCE`, `CW`.
- FSM, output logic and `sw_data` register live in `input_handshake_ctrl`.

## Test plan
- DEBOUNCE=4; `wait_req`=1; `sw`=8'hA5; `ready` high at cycle 10 → `stall` high cycles 0–16, `sw_valid` a single pulse in cycle 17, `sw_data`=8'hA5 (latched build).
- DEBOUNCE=4; 3-cycle `ready` glitch during WAIT_PRESS → `db` stays 0, no `sw_valid`, `stall` remains high.
- `ready` already high when `wait_req` asserts → FSM enters WAIT_RELEASE with no strobe; release then press → exactly one `sw_valid`.
- Two consecutive input instructions with `ready` held high → the second stays stalled until release plus a new press; total strobes = 2.
- `reset` asserted asynchronously in WAIT_PRESS → same-cycle return to IDLE, `busy` 0, `sw_data` 0; with `ready` still held, a strobe follows DEBOUNCE+3 cycles after `reset` drops.
- Latched build: `sw` changes from 8'h3C to 8'hFF after the strobe → `sw_data` stays 8'h3C. Unlatched build: `sw_data` follows `sw` immediately.
